// File: rtl/eeprom_keymap_store.sv
// Keymap store backed by an I2C EEPROM controller.
// Holds NUM_KEYS 8-bit entries with per-entry dirty bits. A load reads every entry from
// EEPROM (BASE_ADDR + index); a save writes back only dirty entries. Host writes mark
// entries dirty. Each byte transfer is guarded by a TIMEOUT-cycle watchdog.
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_load_req, i_save_req         request pulses (load wins; save while busy is queued)
//   i_wr_en/i_wr_index/i_wr_value  host entry write
//   i_rd_index/o_rd_value          combinational entry read (out of range reads 8'h00)
//   o_ee_start/o_ee_rw/o_ee_address/o_ee_data_in  command to the EEPROM controller
//   i_ee_data_out/i_ee_done        read data and one-cycle completion pulse
//   o_busy/o_loaded/o_error        status (error is sticky)
module eeprom_keymap_store #(
   parameter int unsigned NUM_KEYS  = 6,
   parameter logic [7:0]  BASE_ADDR = 8'h00,
   parameter bit          AUTO_LOAD = 1'b1,
   parameter int unsigned TIMEOUT   = 2_000_000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_load_req,
   input  logic       i_save_req,
   input  logic       i_wr_en,
   input  logic [3:0] i_wr_index,
   input  logic [7:0] i_wr_value,
   input  logic [3:0] i_rd_index,
   output logic [7:0] o_rd_value,
   output logic       o_ee_start,
   output logic       o_ee_rw,
   output logic [7:0] o_ee_address,
   output logic [7:0] o_ee_data_in,
   input  logic [7:0] i_ee_data_out,
   input  logic       i_ee_done,
   output logic       o_busy,
   output logic       o_loaded,
   output logic       o_error
);

   localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [3:0]       LAST_IDX = 4'(NUM_KEYS - 1);

   typedef enum logic [2:0] {
      StIdle, StLdIssue, StLdWait, StSvScan, StSvIssue, StSvWait
   } state_e;

   state_e              r_state;
   logic [3:0]          r_idx;
   logic [7:0]          r_entry [NUM_KEYS];
   logic [NUM_KEYS-1:0] r_dirty;
   logic                r_pending;
   logic                r_auto;      // one-shot load trigger after reset release
   logic                r_changed;   // entry[idx] rewritten since its save was issued
   logic [CNT_W-1:0]    r_cnt;
   logic                r_ee_start;
   logic                r_ee_rw;
   logic [7:0]          r_ee_address;
   logic [7:0]          r_ee_data_in;
   logic                r_loaded;
   logic                r_error;

   logic       w_loading;
   logic       w_wr_hit;
   logic       w_wr_same;
   logic       w_last;
   logic       w_timeout;
   logic [3:0] w_next_idx;
   logic [7:0] w_cur_entry;
   logic       w_cur_dirty;

   assign w_loading  = (r_state == StLdIssue) || (r_state == StLdWait);
   assign w_wr_hit   = i_wr_en && ({1'b0, i_wr_index} < 5'(NUM_KEYS)) && !w_loading;
   assign w_wr_same  = w_wr_hit && (i_wr_index == r_idx);
   assign w_last     = (r_idx == LAST_IDX);
   assign w_timeout  = (r_cnt == CNT_LAST);
   assign w_next_idx = r_idx + 4'd1;

   // Entry/dirty at the current sequence index.
   always_comb begin
      w_cur_entry = 8'h00;
      w_cur_dirty = 1'b0;
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
         if (r_idx == 4'(i)) begin
            w_cur_entry = r_entry[i];
            w_cur_dirty = r_dirty[i];
         end
      end
   end

   always_comb begin
      o_rd_value = 8'h00;
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
         if (i_rd_index == 4'(i)) o_rd_value = r_entry[i];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= StIdle;
         r_idx        <= 4'd0;
         for (int i = 0; i < int'(NUM_KEYS); i++) r_entry[i] <= 8'h00;
         r_dirty      <= '0;
         r_pending    <= 1'b0;
         r_auto       <= AUTO_LOAD;
         r_changed    <= 1'b0;
         r_cnt        <= '0;
         r_ee_start   <= 1'b0;
         r_ee_rw      <= 1'b0;
         r_ee_address <= 8'h00;
         r_ee_data_in <= 8'h00;
         r_loaded     <= 1'b0;
         r_error      <= 1'b0;
      end else begin
         r_ee_start <= 1'b0;
         // Queue saves that arrive mid-sequence; the timeout abort below may override.
         if (i_save_req && (r_state != StIdle)) r_pending <= 1'b1;

         case (r_state)
            StIdle: begin
               if (i_load_req || r_auto) begin
                  r_auto       <= 1'b0;
                  r_error      <= 1'b0;
                  r_pending    <= r_pending || i_save_req;
                  r_idx        <= 4'd0;
                  r_cnt        <= '0;
                  r_ee_start   <= 1'b1;
                  r_ee_rw      <= 1'b1;
                  r_ee_address <= BASE_ADDR;
                  r_state      <= StLdIssue;
               end else if (i_save_req || r_pending) begin
                  r_error   <= 1'b0;
                  r_pending <= 1'b0;
                  r_idx     <= 4'd0;
                  r_state   <= StSvScan;
               end
            end
            StLdIssue: begin
               r_cnt   <= r_cnt + CNT_W'(1);
               r_state <= StLdWait;
            end
            StLdWait: begin
               if (i_ee_done) begin
                  for (int i = 0; i < int'(NUM_KEYS); i++) begin
                     if (r_idx == 4'(i)) begin
                        r_entry[i] <= i_ee_data_out;
                        r_dirty[i] <= 1'b0;
                     end
                  end
                  if (w_last) begin
                     r_loaded <= 1'b1;
                     r_idx    <= 4'd0;
                     r_state  <= StIdle;
                  end else begin
                     r_idx        <= w_next_idx;
                     r_cnt        <= '0;
                     r_ee_start   <= 1'b1;
                     r_ee_address <= BASE_ADDR + {4'h0, w_next_idx};
                     r_state      <= StLdIssue;
                  end
               end else if (w_timeout) begin
                  r_error   <= 1'b1;
                  r_pending <= 1'b0;
                  r_idx     <= 4'd0;
                  r_state   <= StIdle;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            StSvScan: begin
               if (w_cur_dirty) begin
                  r_cnt        <= '0;
                  r_changed    <= 1'b0;
                  r_ee_start   <= 1'b1;
                  r_ee_rw      <= 1'b0;
                  r_ee_address <= BASE_ADDR + {4'h0, r_idx};
                  // Send the value the entry holds after this cycle's host write, if any.
                  r_ee_data_in <= w_wr_same ? i_wr_value : w_cur_entry;
                  r_state      <= StSvIssue;
               end else if (w_last) begin
                  r_idx   <= 4'd0;
                  r_state <= StIdle;
               end else begin
                  r_idx <= w_next_idx;
               end
            end
            StSvIssue: begin
               r_cnt   <= r_cnt + CNT_W'(1);
               r_state <= StSvWait;
               if (w_wr_same) r_changed <= 1'b1;
            end
            StSvWait: begin
               if (i_ee_done) begin
                  // A host write during the transfer keeps the entry dirty.
                  if (!(r_changed || w_wr_same)) begin
                     for (int i = 0; i < int'(NUM_KEYS); i++) begin
                        if (r_idx == 4'(i)) r_dirty[i] <= 1'b0;
                     end
                  end
                  if (w_last) begin
                     r_idx   <= 4'd0;
                     r_state <= StIdle;
                  end else begin
                     r_idx   <= w_next_idx;
                     r_state <= StSvScan;
                  end
               end else if (w_timeout) begin
                  r_error   <= 1'b1;
                  r_pending <= 1'b0;
                  r_idx     <= 4'd0;
                  r_state   <= StIdle;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (w_wr_same) r_changed <= 1'b1;
               end
            end
            default: r_state <= StIdle;
         endcase

         // Host writes come last so they win over any dirty clear above.
         for (int i = 0; i < int'(NUM_KEYS); i++) begin
            if (w_wr_hit && (i_wr_index == 4'(i))) begin
               r_entry[i] <= i_wr_value;
               r_dirty[i] <= 1'b1;
            end
         end
      end
   end

   assign o_ee_start   = r_ee_start;
   assign o_ee_rw      = r_ee_rw;
   assign o_ee_address = r_ee_address;
   assign o_ee_data_in = r_ee_data_in;
   assign o_busy       = (r_state != StIdle);
   assign o_loaded     = r_loaded;
   assign o_error      = r_error;

endmodule

// File: tb/tb_eeprom_keymap_store.sv
// Directed bench for eeprom_keymap_store with a small EEPROM controller model that logs
// every command and answers after a fixed latency (or never, when muted).
module tb_eeprom_keymap_store;

   localparam int unsigned NK  = 6;
   localparam int unsigned TO  = 100;
   localparam int          LAT = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       load_req, save_req, wr_en;
   logic [3:0] wr_index, rd_index;
   logic [7:0] wr_value, rd_value;
   logic       ee_start, ee_rw, ee_done;
   logic [7:0] ee_address, ee_data_in, ee_data_out;
   logic       busy, loaded, error;

   logic [7:0] mem [256];
   int         cmd_n;
   logic       cmd_rw   [64];
   logic [7:0] cmd_addr [64];
   logic [7:0] cmd_data [64];
   bit         mute;
   bit         hook_en;
   logic [3:0] hook_idx;
   logic [7:0] hook_val;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   eeprom_keymap_store #(
      .NUM_KEYS  (NK),
      .BASE_ADDR (8'h00),
      .AUTO_LOAD (1'b1),
      .TIMEOUT   (TO)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_load_req    (load_req),
      .i_save_req    (save_req),
      .i_wr_en       (wr_en),
      .i_wr_index    (wr_index),
      .i_wr_value    (wr_value),
      .i_rd_index    (rd_index),
      .o_rd_value    (rd_value),
      .o_ee_start    (ee_start),
      .o_ee_rw       (ee_rw),
      .o_ee_address  (ee_address),
      .o_ee_data_in  (ee_data_in),
      .i_ee_data_out (ee_data_out),
      .i_ee_done     (ee_done),
      .o_busy        (busy),
      .o_loaded      (loaded),
      .o_error       (error)
   );

   // EEPROM controller model.
   initial begin
      logic       c_rw;
      logic [7:0] c_addr, c_data;
      bit         aborted, skip_wait, hooked;
      ee_done     = 1'b0;
      ee_data_out = 8'h00;
      skip_wait   = 1'b0;
      forever begin
         if (!skip_wait) @(negedge clk);
         skip_wait = 1'b0;
         if (rst_n === 1'b1 && ee_start === 1'b1) begin
            c_rw   = ee_rw;
            c_addr = ee_address;
            c_data = ee_data_in;
            if (cmd_n < 64) begin
               cmd_rw[cmd_n]   = c_rw;
               cmd_addr[cmd_n] = c_addr;
               cmd_data[cmd_n] = c_data;
            end
            cmd_n++;
            if (!mute) begin
               aborted = 1'b0;
               for (int k = 0; k < LAT; k++) begin
                  @(negedge clk);
                  if (rst_n !== 1'b1) aborted = 1'b1;
               end
               if (!aborted) begin
                  n_checks++;
                  if (ee_rw !== c_rw || ee_address !== c_addr || ee_data_in !== c_data)
                     $display("FAIL cmd_stable: got %b/%h/%h required %b/%h/%h",
                              ee_rw, ee_address, ee_data_in, c_rw, c_addr, c_data);
                  else n_pass++;
                  if (c_rw) ee_data_out = mem[c_addr];
                  else mem[c_addr] = c_data;
                  hooked = hook_en && !c_rw && (c_addr == {4'h0, hook_idx});
                  if (hooked) begin
                     wr_en    = 1'b1;
                     wr_index = hook_idx;
                     wr_value = hook_val;
                  end
                  ee_done = 1'b1;
                  @(negedge clk);
                  ee_done = 1'b0;
                  if (hooked) begin
                     wr_en   = 1'b0;
                     hook_en = 1'b0;
                  end
                  skip_wait = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic host_write(input logic [3:0] idx, input logic [7:0] val);
      @(negedge clk);
      wr_en = 1'b1; wr_index = idx; wr_value = val;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic pulse_load();
      @(negedge clk); load_req = 1'b1;
      @(negedge clk); load_req = 1'b0;
   endtask

   task automatic pulse_save();
      @(negedge clk); save_req = 1'b1;
      @(negedge clk); save_req = 1'b0;
   endtask

   task automatic wait_idle(input int bound, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < bound; k++) begin
         @(negedge clk);
         if (busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; load_req = 1'b0; save_req = 1'b0; wr_en = 1'b0;
      wr_index = 4'd0; wr_value = 8'h00; rd_index = 4'd0;
      mute = 1'b0; hook_en = 1'b0; cmd_n = 0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      for (int i = 0; i < 6; i++) mem[i] = 8'h11 + 8'(i);
      repeat (3) @(negedge clk);
      n_checks++;
      if ({ee_start, ee_rw, ee_address, ee_data_in} !== 18'h0)
         $display("FAIL reset_ee: got %h required 0", {ee_start, ee_rw, ee_address, ee_data_in});
      else n_pass++;
      n_checks++;
      if ({busy, loaded, error} !== 3'b000)
         $display("FAIL reset_status: got %b required 000", {busy, loaded, error});
      else n_pass++;
      n_checks++;
      if (rd_value !== 8'h00) $display("FAIL reset_entry: got %h required 00", rd_value);
      else n_pass++;
   endtask

   task automatic test_auto_load();
      bit ok;
      logic [7:0] exp;
      cmd_n = 0;
      rst_n = 1'b1;
      wait_idle(300, ok);
      n_checks++;
      if (!ok) $display("FAIL auto_load_done: busy stuck, required idle");
      else n_pass++;
      n_checks++;
      if (cmd_n !== 6) $display("FAIL auto_load_cmds: got %0d required 6", cmd_n);
      else n_pass++;
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if ({cmd_rw[i], cmd_addr[i]} !== {1'b1, 8'(i)})
            $display("FAIL auto_load_cmd%0d: got %b/%h required 1/%h", i, cmd_rw[i],
                     cmd_addr[i], 8'(i));
         else n_pass++;
      end
      for (int i = 0; i < 6; i++) begin
         rd_index = 4'(i);
         exp = 8'h11 + 8'(i);
         #1;
         n_checks++;
         if (rd_value !== exp)
            $display("FAIL auto_load_entry%0d: got %h required %h", i, rd_value, exp);
         else n_pass++;
      end
      n_checks++;
      if ({loaded, busy} !== 2'b10)
         $display("FAIL auto_load_status: got %b required 10", {loaded, busy});
      else n_pass++;
   endtask

   task automatic test_save();
      bit ok;
      cmd_n = 0;
      host_write(4'd2, 8'hA5);
      host_write(4'd4, 8'h3C);
      pulse_save();
      wait_idle(300, ok);
      n_checks++;
      if (!ok || cmd_n !== 2) $display("FAIL save_cmds: got %0d required 2", cmd_n);
      else n_pass++;
      n_checks++;
      if ({cmd_rw[0], cmd_addr[0], cmd_data[0]} !== {1'b0, 8'h02, 8'hA5})
         $display("FAIL save_cmd0: got %h required 002a5", {cmd_rw[0], cmd_addr[0], cmd_data[0]});
      else n_pass++;
      n_checks++;
      if ({cmd_rw[1], cmd_addr[1], cmd_data[1]} !== {1'b0, 8'h04, 8'h3C})
         $display("FAIL save_cmd1: got %h required 0043c", {cmd_rw[1], cmd_addr[1], cmd_data[1]});
      else n_pass++;
      rd_index = 4'd2; #1;
      n_checks++;
      if (rd_value !== 8'hA5) $display("FAIL save_entry2: got %h required a5", rd_value);
      else n_pass++;
      // Dirty bits are clear: a second save issues nothing.
      cmd_n = 0;
      pulse_save();
      wait_idle(300, ok);
      n_checks++;
      if (!ok || cmd_n !== 0) $display("FAIL save_clean: got %0d cmds required 0", cmd_n);
      else n_pass++;
   endtask

   task automatic test_write_during_done();
      bit ok;
      cmd_n = 0;
      host_write(4'd2, 8'h55);
      hook_idx = 4'd2; hook_val = 8'h77; hook_en = 1'b1;
      pulse_save();
      wait_idle(300, ok);
      n_checks++;
      if (!ok || cmd_n !== 1 || {cmd_addr[0], cmd_data[0]} !== 16'h0255)
         $display("FAIL race_first_save: got %0d cmds %h/%h required 1 cmd 02/55", cmd_n,
                  cmd_addr[0], cmd_data[0]);
      else n_pass++;
      rd_index = 4'd2; #1;
      n_checks++;
      if (rd_value !== 8'h77) $display("FAIL race_entry: got %h required 77", rd_value);
      else n_pass++;
      cmd_n = 0;
      pulse_save();
      wait_idle(300, ok);
      n_checks++;
      if (!ok || cmd_n !== 1 || {cmd_rw[0], cmd_addr[0], cmd_data[0]} !== {1'b0, 16'h0277})
         $display("FAIL race_second_save: got %0d cmds %h/%h required 1 cmd 02/77", cmd_n,
                  cmd_addr[0], cmd_data[0]);
      else n_pass++;
   endtask

   task automatic test_range();
      bit ok;
      host_write(4'd7, 8'hEE);
      host_write(4'd6, 8'hDD);
      rd_index = 4'd9; #1;
      n_checks++;
      if (rd_value !== 8'h00) $display("FAIL range_rd9: got %h required 00", rd_value);
      else n_pass++;
      rd_index = 4'd6; #1;
      n_checks++;
      if (rd_value !== 8'h00) $display("FAIL range_rd6: got %h required 00", rd_value);
      else n_pass++;
      rd_index = 4'd5; #1;
      n_checks++;
      if (rd_value !== 8'h16) $display("FAIL range_entry5: got %h required 16", rd_value);
      else n_pass++;
      cmd_n = 0;
      pulse_save();
      wait_idle(300, ok);
      n_checks++;
      if (!ok || cmd_n !== 0) $display("FAIL range_nodirty: got %0d cmds required 0", cmd_n);
      else n_pass++;
   endtask

   task automatic test_save_during_load();
      bit ok;
      int hi;
      cmd_n = 0;
      pulse_load();
      repeat (4) @(negedge clk);
      pulse_load();  // ignored while busy
      pulse_save();  // queued
      wait_idle(300, ok);
      n_checks++;
      if (!ok || cmd_n !== 6 || loaded !== 1'b1)
         $display("FAIL sdl_load: got %0d cmds loaded=%b required 6 cmds loaded=1", cmd_n, loaded);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) $display("FAIL sdl_pending_start: got busy=%b required 1", busy);
      else n_pass++;
      hi = 1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (busy === 1'b1) hi++;
         else break;
      end
      n_checks++;
      if (hi !== 6) $display("FAIL sdl_scan_len: got %0d cycles required 6", hi);
      else n_pass++;
      rd_index = 4'd2; #1;
      n_checks++;
      if (rd_value !== 8'h77 || cmd_n !== 6)
         $display("FAIL sdl_reload: got %h/%0d cmds required 77/6", rd_value, cmd_n);
      else n_pass++;
   endtask

   task automatic test_timeout();
      bit ok, found;
      mute = 1'b1;
      cmd_n = 0;
      host_write(4'd3, 8'h42);
      pulse_save();
      found = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (ee_start === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!found) $display("FAIL to_issue: got no ee_start required one");
      else n_pass++;
      repeat (99) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({error, busy} !== 2'b01)
         $display("FAIL to_before: got err/busy=%b required 01", {error, busy});
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({error, busy} !== 2'b10)
         $display("FAIL to_at_limit: got err/busy=%b required 10", {error, busy});
      else n_pass++;
      repeat (3) @(negedge clk);
      n_checks++;
      if (error !== 1'b1) $display("FAIL to_sticky: got %b required 1", error);
      else n_pass++;
      mute = 1'b0;
      pulse_save();
      n_checks++;
      if (error !== 1'b0) $display("FAIL to_clear: got %b required 0", error);
      else n_pass++;
      wait_idle(300, ok);
      n_checks++;
      if (!ok || cmd_n !== 2 || {cmd_rw[1], cmd_addr[1], cmd_data[1]} !== {1'b0, 16'h0342})
         $display("FAIL to_retry: got %0d cmds %h/%h required 2 cmds last 03/42", cmd_n,
                  cmd_addr[1], cmd_data[1]);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      bit ok;
      int starts;
      pulse_load();
      starts = 1;  // first ee_start is visible at the negedge pulse_load returns on
      for (int k = 0; k < 200; k++) begin
         if (starts >= 3) break;
         @(negedge clk);
         if (ee_start === 1'b1) starts++;
      end
      @(negedge clk);
      rd_index = 4'd0;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({ee_start, ee_rw, ee_address, ee_data_in} !== 18'h0)
         $display("FAIL rmid_ee: got %h required 0", {ee_start, ee_rw, ee_address, ee_data_in});
      else n_pass++;
      n_checks++;
      if ({busy, loaded, error, rd_value} !== 11'h0)
         $display("FAIL rmid_status: got %b/%h required 000/00", {busy, loaded, error}, rd_value);
      else n_pass++;
      cmd_n = 0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (cmd_n !== 0) $display("FAIL rmid_quiet: got %0d cmds required 0", cmd_n);
      else n_pass++;
      rst_n = 1'b1;
      wait_idle(300, ok);
      n_checks++;
      if (!ok || cmd_n !== 6 || {cmd_rw[0], cmd_addr[0]} !== 9'h100 || loaded !== 1'b1)
         $display("FAIL rmid_reload: got %0d cmds first %b/%h loaded=%b required 6/1/00/1",
                  cmd_n, cmd_rw[0], cmd_addr[0], loaded);
      else n_pass++;
      rd_index = 4'd5; #1;
      n_checks++;
      if (rd_value !== 8'h16) $display("FAIL rmid_entry5: got %h required 16", rd_value);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_auto_load();
      test_save();
      test_write_during_done();
      test_range();
      test_save_during_load();
      test_timeout();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/eeprom_keymap_store.md
EEPROM_KEYMAP_STORE -- requirements
Module: eeprom_keymap_store

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 6, meaning the number of 8-bit keymap entries held (1..16).
REQ-002 SHALL have parameter BASE_ADDR, default 8'h00, meaning the EEPROM byte address of entry 0.
REQ-003 SHALL have parameter AUTO_LOAD, default 1, meaning a load starts automatically after reset release.
REQ-004 SHALL have parameter TIMEOUT, default 2_000_000, meaning the maximum clk cycles to wait for ee_done per byte.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk  in  1  system clock; rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: load_req  in  1  pulse, reload all entries from EEPROM.
REQ-007 save_req  in  1  pulse, write all dirty entries to EEPROM.
REQ-008 wr_en  in  1  host entry write strobe; wr_index  in  4  entry index; wr_value  in  8  entry data.
REQ-009 rd_index  in  4  entry index; rd_value  out  8  entry data (combinational).
REQ-010 ee_start  out  1; ee_rw  out  1 (1=read); ee_address  out  8; ee_data_in  out  8: command to the I2C EEPROM controller.
REQ-011 ee_data_out  in  8; ee_done  in  1: result and one-cycle completion pulse from the controller.
REQ-012 busy  out  1  load/save in progress; loaded  out  1  first load complete; error  out  1  sticky timeout flag.

Function
REQ-013 SHALL hold NUM_KEYS 8-bit entries, each with a dirty bit.
REQ-014 SHALL use states IDLE, LD_ISSUE, LD_WAIT, SV_SCAN, SV_ISSUE, SV_WAIT; busy=1 in every state except IDLE.
REQ-015 IDLE: load_req (or first cycle after reset when AUTO_LOAD=1) -> idx=0, LD_ISSUE; else save_req or pending save -> idx=0, SV_SCAN; load wins if both.
REQ-016 LD_ISSUE: ee_start=1 for exactly one cycle, ee_rw=1, ee_address=BASE_ADDR+idx (8-bit wrap) -> LD_WAIT.
REQ-017 LD_WAIT: on ee_done, entry[idx]<=ee_data_out, dirty[idx]<=0; if idx==NUM_KEYS-1 -> loaded<=1, IDLE; else idx+1, LD_ISSUE.
REQ-018 SV_SCAN: examine one entry per cycle; dirty -> SV_ISSUE; clean -> idx+1; after idx NUM_KEYS-1 -> IDLE.
REQ-019 SV_ISSUE: ee_start=1 for one cycle, ee_rw=0, ee_address=BASE_ADDR+idx, ee_data_in=entry[idx] captured this cycle -> SV_WAIT.
REQ-020 SV_WAIT: on ee_done, clear dirty[idx] only if entry unchanged since SV_ISSUE, then idx+1 -> SV_SCAN (or IDLE after last).
REQ-021 ee_start SHALL be 0 in all other states; ee_rw/ee_address/ee_data_in SHALL stay stable from issue until ee_done.
REQ-022 wr_en with wr_index<NUM_KEYS SHALL write entry and set dirty in any state except LD_ISSUE/LD_WAIT, where it is ignored.
REQ-023 wr_en in the same cycle as SV_WAIT ee_done on the same index: new value stored, dirty stays 1.
REQ-024 wr_index>=NUM_KEYS: write ignored; rd_index>=NUM_KEYS: rd_value=8'h00.
REQ-025 save_req while busy SHALL set a pending flag serviced on return to IDLE; load_req while busy SHALL be ignored.
REQ-026 Wait counter SHALL clear at each issue; reaching TIMEOUT in LD_WAIT/SV_WAIT SHALL set error=1, abort the sequence, go IDLE, clear pending; entry and dirty unchanged for that index.
REQ-027 error SHALL clear only on reset or on the next load_req/save_req accepted in IDLE.

Reset
REQ-028 On rst_n=0 asynchronously: state IDLE, idx 0, all entries 8'h00, dirty 0, pending 0, ee_start 0, ee_rw 0, ee_address 0, ee_data_in 0, busy 0, loaded 0, error 0.
REQ-029 Reset mid-operation SHALL abandon the transfer with no further ee_start; AUTO_LOAD restarts the load after release.

Verification
REQ-030 AUTO_LOAD=1, EEPROM model bytes 0x11..0x16 at 0x00..0x05 -> six read commands addr 0..5, rd_value(i)=0x11+i, loaded=1, busy=0.
REQ-031 Write entry 2=0xA5, entry 4=0x3C, save_req -> exactly two write commands (0x02,0xA5),(0x04,0x3C) in order; dirty cleared.
REQ-032 wr_en index 2 value 0x77 in the cycle ee_done ends write of index 2 -> entry=0x77, second save writes (0x02,0x77).
REQ-033 TIMEOUT=100, model never asserts ee_done -> error=1 at 100 cycles after ee_start, busy=0; next save_req clears error.
REQ-034 save_req during load -> save starts immediately after loaded=1; wr_index=7 or rd_index=9 -> no write, rd_value=0x00.
REQ-035 rst_n low during LD_WAIT -> all outputs reset values at once; new load starts at address BASE_ADDR after release.
